// File: rtl/seq_mul_shift_add.sv
// seq_mul_shift_add
//   Multi-cycle shift-and-add multiplier. One partial product is folded into
//   the accumulator per clock, so a multiply takes B_WIDTH cycles in RUN plus
//   one cycle in DONE. A_WIDTH and B_WIDTH set the operand widths. SIGNED
//   selects unsigned (0) or two's-complement (1) operation at elaboration.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request, honoured only in IDLE or DONE
//   a        multiplicand, captured when start is accepted
//   b        multiplier, captured when start is accepted
//   busy     high while the iterations are running
//   done     one-cycle pulse when product has just been updated
//   product  result register, held until the next completion

module seq_mul_shift_add #(
  parameter int A_WIDTH = 5,
  parameter int B_WIDTH = 5,
  parameter int SIGNED  = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
  output logic                       busy,
  output logic                       done,
  output logic [A_WIDTH+B_WIDTH-1:0] product
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;
  localparam int C_WIDTH = (B_WIDTH > 1) ? $clog2(B_WIDTH) : 1;
  localparam logic [C_WIDTH-1:0] LAST_COUNT = C_WIDTH'(B_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 load;
  logic                 step;
  logic                 last;
  logic [P_WIDTH-1:0]   ext_a;
  logic [P_WIDTH-1:0]   mcand;
  logic [B_WIDTH-1:0]   mplier;
  logic [P_WIDTH-1:0]   acc;
  logic [P_WIDTH-1:0]   addend;
  logic [P_WIDTH-1:0]   acc_next;
  logic [C_WIDTH-1:0]   count;

  // The multiplicand is widened once at capture time; in signed mode the
  // sign extension makes every shifted partial product correct modulo
  // 2^P_WIDTH.
  assign ext_a = (SIGNED != 0) ? {{B_WIDTH{a[A_WIDTH-1]}}, a}
                               : {{B_WIDTH{1'b0}}, a};

  // The multiplicand register is shifted left and the multiplier register
  // shifted right every iteration, so mcand already holds a << count and
  // mplier[0] is multiplier bit[count]; no barrel shifter is needed.
  // In signed mode the multiplier MSB carries negative weight, so the last
  // iteration subtracts its partial product instead of adding it.
  assign last     = (count == LAST_COUNT);
  assign addend   = mplier[0] ? mcand : '0;
  assign acc_next = ((SIGNED != 0) && last) ? (acc - addend) : (acc + addend);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and datapath controls. DONE accepts start exactly like
  // IDLE so that a held start gives back-to-back operation; start in RUN
  // is ignored.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath registers. product is only written on the final iteration, so
  // it holds the previous result throughout the next operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
    end else if (load) begin
      mcand  <= ext_a;
      mplier <= b;
      acc    <= '0;
      count  <= '0;
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= last ? '0 : (count + C_WIDTH'(1));
      if (last) begin
        product <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_seq_mul_shift_add.sv
// tb_seq_mul_shift_add
//   Directed bench for seq_mul_shift_add. Four instances cover the default
//   unsigned 5x5 unit, a signed 5x5 unit and 8x3 units in both modes.
//   Inputs are driven on the falling edge and outputs observed there too.

module tb_seq_mul_shift_add;

  logic        clk;
  logic        rst_n;
  logic [3:0]  start_v;
  logic [7:0]  a_in;
  logic [4:0]  b_in;
  logic [3:0]  busy_v;
  logic [3:0]  done_v;
  logic [9:0]  p0;
  logic [9:0]  p1;
  logic [10:0] p2;
  logic [10:0] p3;
  logic [10:0] prod_v [4];

  int total;
  int bad;

  seq_mul_shift_add #(.A_WIDTH(5), .B_WIDTH(5), .SIGNED(0)) u_u55 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_in[4:0]), .b(b_in),
    .busy(busy_v[0]), .done(done_v[0]), .product(p0));

  seq_mul_shift_add #(.A_WIDTH(5), .B_WIDTH(5), .SIGNED(1)) u_s55 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_in[4:0]), .b(b_in),
    .busy(busy_v[1]), .done(done_v[1]), .product(p1));

  seq_mul_shift_add #(.A_WIDTH(8), .B_WIDTH(3), .SIGNED(0)) u_u83 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_in), .b(b_in[2:0]),
    .busy(busy_v[2]), .done(done_v[2]), .product(p2));

  seq_mul_shift_add #(.A_WIDTH(8), .B_WIDTH(3), .SIGNED(1)) u_s83 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .a(a_in), .b(b_in[2:0]),
    .busy(busy_v[3]), .done(done_v[3]), .product(p3));

  assign prod_v[0] = {1'b0, p0};
  assign prod_v[1] = {1'b0, p1};
  assign prod_v[2] = p2;
  assign prod_v[3] = p3;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts one operation on instance sel from idle and gathers what happens:
  // busy right after acceptance, cycles from the accepting edge to done
  // (20 means done never came), the product, and done one cycle later.
  task automatic run_op(input int sel, input logic [7:0] av, input logic [4:0] bv,
                        output logic [10:0] prod, output int lat,
                        output logic busy0, output logic done_after);
    @(negedge clk);
    a_in = av;
    b_in = bv;
    start_v[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[sel] = 1'b0;
    busy0 = busy_v[sel];
    lat = 0;
    while (done_v[sel] !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    prod = prod_v[sel];
    @(negedge clk);
    done_after = done_v[sel];
  endtask

  // Reset state, then 20 idle cycles with start low.
  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #3;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || prod_v[i] !== 11'd0) begin
        bad++;
        $display("[TB] FAIL reset_state inst=%0d busy=%b done=%b product=%0d, required 0/0/0",
                 i, busy_v[i], done_v[i], prod_v[i]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        total++;
        if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || prod_v[i] !== 11'd0) begin
          bad++;
          $display("[TB] FAIL idle_hold inst=%0d cycle=%0d busy=%b done=%b product=%0d, required 0/0/0",
                   i, c, busy_v[i], done_v[i], prod_v[i]);
        end
      end
    end
  endtask

  // Unsigned 5x5 corner products with latency and pulse width.
  task automatic test_unsigned();
    logic [7:0]  ta [4] = '{8'd31, 8'd0, 8'd1, 8'd16};
    logic [4:0]  tb [4] = '{5'd31, 5'd27, 5'd19, 5'd2};
    logic [10:0] te [4] = '{11'd961, 11'd0, 11'd19, 11'd32};
    logic [10:0] prod;
    int          lat;
    logic        busy0;
    logic        done_after;
    for (int i = 0; i < 4; i++) begin
      run_op(0, ta[i], tb[i], prod, lat, busy0, done_after);
      total++;
      if (prod !== te[i]) begin
        bad++;
        $display("[TB] FAIL unsigned_product %0d*%0d got %0d, required %0d", ta[i], tb[i], prod, te[i]);
      end
      total++;
      if (lat !== 5) begin
        bad++;
        $display("[TB] FAIL unsigned_latency %0d*%0d got %0d cycles, required 5", ta[i], tb[i], lat);
      end
      total++;
      if (busy0 !== 1'b1 || done_after !== 1'b0) begin
        bad++;
        $display("[TB] FAIL unsigned_handshake busy_after_accept=%b done_next=%b, required 1/0",
                 busy0, done_after);
      end
    end
  endtask

  // Signed 5x5 products, 10-bit two's-complement results.
  task automatic test_signed();
    logic [7:0]  ta [4] = '{8'h10, 8'h10, 8'h1F, 8'h07};
    logic [4:0]  tb [4] = '{5'h10, 5'h0F, 5'h1F, 5'h1D};
    logic [10:0] te [4] = '{11'h100, 11'h310, 11'h001, 11'h3EB};
    logic [10:0] prod;
    int          lat;
    logic        busy0;
    logic        done_after;
    for (int i = 0; i < 4; i++) begin
      run_op(1, ta[i], tb[i], prod, lat, busy0, done_after);
      total++;
      if (prod !== te[i] || lat !== 5) begin
        bad++;
        $display("[TB] FAIL signed_product a=%h b=%h got %h after %0d cycles, required %h after 5",
                 ta[i][4:0], tb[i], prod, lat, te[i]);
      end
    end
  endtask

  // start pulsed with new operands mid-RUN must be ignored.
  task automatic test_capture();
    int dcnt = 0;
    @(negedge clk);
    a_in = 8'd9;
    b_in = 5'd11;
    start_v[0] = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      if (n == 2) begin
        start_v[0] = 1'b1;
        a_in = 8'd31;
        b_in = 5'd31;
      end else begin
        start_v[0] = 1'b0;
      end
      if (done_v[0] === 1'b1) begin
        dcnt++;
        total++;
        if (n !== 5 || prod_v[0] !== 11'd99) begin
          bad++;
          $display("[TB] FAIL capture_result at cycle %0d product=%0d, required cycle 5 product 99",
                   n, prod_v[0]);
        end
      end
    end
    total++;
    if (dcnt !== 1) begin
      bad++;
      $display("[TB] FAIL capture_done_count got %0d pulses, required 1", dcnt);
    end
  endtask

  // start held high: results 6 cycles apart, new operands captured at each DONE.
  task automatic test_back_to_back();
    int          exp_n [3] = '{5, 11, 17};
    logic [10:0] exp_p [3] = '{11'd12, 11'd30, 11'd31};
    int          k = 0;
    int          overlap = 0;
    @(negedge clk);
    a_in = 8'd3;
    b_in = 5'd4;
    start_v[0] = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (busy_v[0] === 1'b1 && done_v[0] === 1'b1) overlap++;
      if (done_v[0] === 1'b1) begin
        total++;
        if (k > 2 || n !== exp_n[k] || prod_v[0] !== exp_p[k]) begin
          bad++;
          $display("[TB] FAIL b2b_result index=%0d cycle=%0d product=%0d, required cycle %0d product %0d",
                   k, n, prod_v[0], (k > 2) ? -1 : exp_n[k], (k > 2) ? 11'd0 : exp_p[k]);
        end
        k++;
        if (k == 1) begin a_in = 8'd5;  b_in = 5'd6; end
        if (k == 2) begin a_in = 8'd31; b_in = 5'd1; end
        if (k >= 3) start_v[0] = 1'b0;
      end
    end
    start_v[0] = 1'b0;
    total++;
    if (k !== 3 || overlap !== 0) begin
      bad++;
      $display("[TB] FAIL b2b_count results=%0d overlap_cycles=%0d, required 3 and 0", k, overlap);
    end
  endtask

  // Reset during iteration 2 of 3*7 discards the operation.
  task automatic test_reset_mid();
    logic [10:0] prod;
    int          lat;
    logic        busy0;
    logic        done_after;
    int          dcnt = 0;
    @(negedge clk);
    a_in = 8'd3;
    b_in = 5'd7;
    start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || prod_v[0] !== 11'd0) begin
      bad++;
      $display("[TB] FAIL reset_mid_clear busy=%b done=%b product=%0d, required 0/0/0",
               busy_v[0], done_v[0], prod_v[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done_v[0] === 1'b1 || busy_v[0] === 1'b1) dcnt++;
    end
    total++;
    if (dcnt !== 0) begin
      bad++;
      $display("[TB] FAIL reset_mid_quiet got %0d active cycles after reset, required 0", dcnt);
    end
    run_op(0, 8'd5, 5'd6, prod, lat, busy0, done_after);
    total++;
    if (prod !== 11'd30 || lat !== 5) begin
      bad++;
      $display("[TB] FAIL reset_mid_recover got %0d after %0d cycles, required 30 after 5", prod, lat);
    end
  endtask

  // 8x3 units in both modes: extremes then random operands vs integer model.
  task automatic test_sweep();
    logic [10:0] prod;
    int          lat;
    logic        busy0;
    logic        done_after;
    logic [7:0]  av;
    logic [4:0]  bv;
    int          sa;
    int          sb;
    logic [10:0] expv;
    for (int i = 0; i < 20; i++) begin
      int sel = (i < 10) ? 2 : 3;
      if (i == 0) begin
        av = 8'd255; bv = 5'd7;
      end else if (i == 10) begin
        av = 8'h80; bv = 5'd4;
      end else begin
        av = 8'($urandom_range(0, 255));
        bv = 5'($urandom_range(0, 7));
      end
      if (sel == 2) begin
        sa = int'(av);
        sb = int'(bv);
      end else begin
        sa = (av >= 8'd128) ? int'(av) - 256 : int'(av);
        sb = (bv >= 5'd4) ? int'(bv) - 8 : int'(bv);
      end
      expv = 11'(sa * sb);
      run_op(sel, av, bv, prod, lat, busy0, done_after);
      total++;
      if (prod !== expv || lat !== 3) begin
        bad++;
        $display("[TB] FAIL sweep inst=%0d a=%0d b=%0d got %0d after %0d cycles, required %0d after 3",
                 sel, av, bv, prod, lat, expv);
      end
    end
  endtask

  // Test sequence.
  initial begin
    total   = 0;
    bad     = 0;
    start_v = 4'b0000;
    a_in    = 8'd0;
    b_in    = 5'd0;
    rst_n   = 1'b1;
    test_reset();
    test_unsigned();
    test_signed();
    test_capture();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
